fec_burst_ctrl: RTL and testbench

- Per-burst sequencer placed in front of the FEC chain (RS encoder, then convolutional encoder).
- Splits an upstream serial bit stream into FEC blocks and inserts the zero tail bits that terminate the CC trellis at the end of every block.
- Marks block boundaries for the encoders.
- Latches the burst configuration (RS enable, CC rate) and holds it stable for the whole burst.

---
 rtl/fec_burst_ctrl.sv | 159 +++++++++++++++
 tb/tb_fec_burst_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fec_burst_ctrl.sv
// Burst sequencer ahead of the RS/CC encoders: slices the upstream bit stream into blocks,
// appends zero tail bits to terminate the trellis, and holds the burst config stable.
module fec_burst_ctrl #(
  parameter int TAIL_BITS = 8,
  parameter int LEN_W     = 12,
  parameter int NBLK_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_blk_bits,
  input  logic [NBLK_W-1:0] cfg_n_blocks,
  input  logic              cfg_enable_rs,
  input  logic [1:0]        cfg_cc_rate,
  input  logic              in_bits,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              enc_bit,
  output logic              enc_valid,
  input  logic              enc_ready,
  output logic              enc_sob,
  output logic              enc_eob,
  output logic              rs_enable,
  output logic [1:0]        cc_rate,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(TAIL_BITS);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NBLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [LEN_W-1:0]    blk_bits_q, blk_bits_d;
  logic [NBLK_W-1:0]   n_blocks_q, n_blocks_d;
  logic                rs_en_q, rs_en_d;
  logic [1:0]          rate_q, rate_d;
  logic                cfg_err_q, cfg_err_d;

  logic [LEN_W-1:0]    data_last;
  logic [LEN_W-1:0]    blk_last;
  logic [NBLK_W-1:0]   nblk_last;

  // Compare against the last index rather than count+1 so maximum sizes never wrap.
  assign data_last = blk_bits_q - TAIL_LEN - LEN_W'(1);
  assign blk_last  = blk_bits_q - LEN_W'(1);
  assign nblk_last = n_blocks_q - NBLK_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      blk_bits_q <= '0;
      n_blocks_q <= '0;
      rs_en_q    <= 1'b0;
      rate_q     <= 2'd0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_bits_q <= blk_bits_d;
      n_blocks_q <= n_blocks_d;
      rs_en_q    <= rs_en_d;
      rate_q     <= rate_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    blk_bits_d = blk_bits_q;
    n_blocks_d = n_blocks_q;
    rs_en_d    = rs_en_q;
    rate_d     = rate_q;
    cfg_err_d  = 1'b0;
    in_ready   = 1'b0;
    enc_valid  = 1'b0;
    enc_bit    = 1'b0;
    enc_eob    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_blk_bits <= TAIL_LEN) || (cfg_n_blocks == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            blk_bits_d = cfg_blk_bits;
            n_blocks_d = cfg_n_blocks;
            rs_en_d    = cfg_enable_rs;
            rate_d     = cfg_cc_rate;
            bit_cnt_d  = '0;
            blk_cnt_d  = '0;
            state_d    = DATA;
          end
        end
      end

      DATA: begin
        busy      = 1'b1;
        in_ready  = enc_ready;
        enc_valid = in_valid;
        enc_bit   = in_bits;
        if (in_valid && enc_ready) begin
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (bit_cnt_q == data_last) begin
            state_d = TAIL;
          end
        end
      end

      TAIL: begin
        busy      = 1'b1;
        enc_valid = 1'b1;
        enc_eob   = (bit_cnt_q == blk_last);
        if (enc_ready) begin
          if (bit_cnt_q == blk_last) begin
            bit_cnt_d = '0;
            blk_cnt_d = blk_cnt_q + NBLK_W'(1);
            state_d   = (blk_cnt_q == nblk_last) ? DONE : DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        bit_cnt_d = '0;
        blk_cnt_d = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tail positions always have bit_cnt > 0, so this can only fire on a data bit.
  assign enc_sob   = enc_valid && (bit_cnt_q == '0);
  assign rs_enable = rs_en_q;
  assign cc_rate   = rate_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fec_burst_ctrl.sv
// Randomized bench for fec_burst_ctrl; expected stream derived from block arithmetic.
module tb_fec_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] cfg_blk_bits;
  logic [7:0]  cfg_n_blocks;
  logic        cfg_enable_rs;
  logic [1:0]  cfg_cc_rate;
  logic        in_bits, in_valid, in_ready;
  logic        enc_bit, enc_valid, enc_ready;
  logic        enc_sob, enc_eob;
  logic        rs_enable;
  logic [1:0]  cc_rate;
  logic        busy, done, cfg_err;

  int passed = 0;
  int fails  = 0;
  int ntot   = 0;
  bit       last_rs   = 1'b0;
  bit [1:0] last_rate = 2'd0;

  always #5 clk = ~clk;

  fec_burst_ctrl #(.TAIL_BITS(8), .LEN_W(12), .NBLK_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_blk_bits(cfg_blk_bits), .cfg_n_blocks(cfg_n_blocks),
    .cfg_enable_rs(cfg_enable_rs), .cfg_cc_rate(cfg_cc_rate),
    .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready),
    .enc_bit(enc_bit), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_sob(enc_sob), .enc_eob(enc_eob),
    .rs_enable(rs_enable), .cc_rate(cc_rate),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic chk_cfg_out(input string tag);
    chk1({tag, "_rs"}, rs_enable, last_rs);
    chk(({tag, "_rate"}), {30'b0, cc_rate}, {30'b0, last_rate});
  endtask

  task automatic scramble_cfg();
    cfg_blk_bits  = 12'($urandom);
    cfg_n_blocks  = 8'($urandom);
    cfg_enable_rs = 1'($urandom);
    cfg_cc_rate   = 2'($urandom);
  endtask

  task automatic illegal_start(input int blk, input int nb);
    @(negedge clk);
    start = 1'b1;
    cfg_blk_bits = 12'(blk); cfg_n_blocks = 8'(nb);
    cfg_enable_rs = ~last_rs; cfg_cc_rate = ~last_rate;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk1("illegal_cfg_err", cfg_err, 1'b1);
    chk1("illegal_busy", busy, 1'b0);
    chk1("illegal_enc_valid", enc_valid, 1'b0);
    chk_cfg_out("illegal");
    @(negedge clk);
    #1;
    chk1("illegal_cfg_err_clear", cfg_err, 1'b0);
    chk1("illegal_busy2", busy, 1'b0);
  endtask

  // Expected stream: transfer t is position t%blk of block t/blk; the first blk-8
  // positions carry upstream bits in order, the rest are zeros.
  task automatic run_burst(input int blk, input int nb, input bit rs, input bit [1:0] rate,
                           input int vld_pct, input int rdy_pct, input bit rdy_tog,
                           input int gap_at, input bit inject, input int abort_at);
    bit data[$];
    int d, n_xfer, src, t, cyc, pos, gapn;
    bit indata, ev, eb;
    d = blk - 8;
    n_xfer = nb * blk;
    src = 0; t = 0; cyc = 0; gapn = 0;
    for (int i = 0; i < nb * d; i++) data.push_back(1'($urandom));

    @(negedge clk);
    start = 1'b1;
    cfg_blk_bits = 12'(blk); cfg_n_blocks = 8'(nb);
    cfg_enable_rs = rs; cfg_cc_rate = rate;
    in_valid = 1'b0; enc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    last_rs = rs; last_rate = rate;

    while (t < n_xfer && cyc < n_xfer * 20 + 200) begin
      if (abort_at >= 0 && t == abort_at) begin
        reset = 1'b1;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_enc_valid", enc_valid, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        chk1("abort_sob", enc_sob, 1'b0);
        chk1("abort_eob", enc_eob, 1'b0);
        chk1("abort_done", done, 1'b0);
        last_rs = 1'b0; last_rate = 2'd0;
        chk_cfg_out("abort");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("abort_no_done", done, 1'b0);
        chk1("abort_busy2", busy, 1'b0);
        return;
      end
      in_valid = ($urandom_range(99, 0) < vld_pct);
      if (gap_at >= 0 && t == gap_at && gapn < 5) begin
        in_valid = 1'b0;
        gapn++;
      end
      enc_ready = rdy_tog ? (cyc % 2 == 0) : ($urandom_range(99, 0) < rdy_pct);
      in_bits = (src < data.size()) ? data[src] : 1'($urandom);
      start = inject && (cyc == 7);
      #1;
      pos = t % blk;
      indata = (pos < d);
      ev = indata ? in_valid : 1'b1;
      chk1("busy", busy, 1'b1);
      chk1("done_early", done, 1'b0);
      chk1("cfg_err_run", cfg_err, 1'b0);
      chk1("enc_valid", enc_valid, ev);
      chk1("in_ready", in_ready, indata & enc_ready);
      if (ev) begin
        eb = indata ? data[(t / blk) * d + pos] : 1'b0;
        chk1("enc_bit", enc_bit, eb);
        chk1("enc_sob", enc_sob, pos == 0);
        chk1("enc_eob", enc_eob, pos == blk - 1);
      end
      if (ev && enc_ready) begin
        t++;
        if (indata) src++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (t < n_xfer) chk("timeout_transfers", t, n_xfer);

    in_valid = 1'b0;
    enc_ready = 1'($urandom);
    start = inject;
    cfg_blk_bits = 12'd20; cfg_n_blocks = 8'd1;
    cfg_enable_rs = ~rs; cfg_cc_rate = ~rate;
    #1;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk1("done_enc_valid", enc_valid, 1'b0);
    chk1("done_cfg_err", cfg_err, 1'b0);
    chk_cfg_out("done");
    @(negedge clk);
    start = 1'b0;
    #1;
    chk1("done_single", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_cfg_err", cfg_err, 1'b0);
    chk_cfg_out("idle");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_blk_bits = '0; cfg_n_blocks = '0; cfg_enable_rs = 1'b0; cfg_cc_rate = 2'd0;
    in_bits = 1'b1; in_valid = 1'b1; enc_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_enc_valid", enc_valid, 1'b0);
    chk1("rst_sob", enc_sob, 1'b0);
    chk1("rst_eob", enc_eob, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    chk_cfg_out("rst");
    reset = 1'b0;
    in_valid = 1'b0; enc_ready = 1'b0;

    run_burst(16, 1, 1'b1, 2'd2, 100, 100, 1'b0, -1, 1'b0, -1);
    run_burst(12, 3, 1'b0, 2'd1, 100, 0, 1'b1, -1, 1'b0, -1);
    run_burst(16, 2, 1'b1, 2'd3, 100, 100, 1'b0, 19, 1'b0, -1);
    illegal_start(8, 1);
    illegal_start(20, 0);
    run_burst(20, 2, 1'b0, 2'd3, 80, 80, 1'b0, -1, 1'b1, -1);
    run_burst(16, 3, 1'b1, 2'd1, 100, 100, 1'b0, -1, 1'b0, 21);
    run_burst(10, 1, 1'b0, 2'd2, 100, 100, 1'b0, -1, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      run_burst($urandom_range(40, 9), $urandom_range(5, 1), 1'($urandom), 2'($urandom),
                $urandom_range(100, 40), $urandom_range(100, 40), 1'b0, -1, 1'b0, -1);
    end
    run_burst(4095, 2, 1'b1, 2'd0, 100, 100, 1'b0, -1, 1'b0, -1);
    run_burst(9, 255, 1'b0, 2'd1, 75, 75, 1'b0, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, ntot);
    $finish;
  end

endmodule
